// File: rtl/pwm_cmd_bank.sv
// rtl/pwm_cmd_bank.sv - FIFO-fed PWM bank: pops {duty, period} words round-robin into
// double-buffered channels that switch settings only at a period boundary.
`timescale 1ns/1ps
module pwm_cmd_bank #(
    parameter int  NUM_CH   = 4,
    parameter int  CNT_W    = 8,
    parameter int  PRESCALE = 1,
    localparam int PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [2*CNT_W-1:0]   fifo_rd_data,
    output logic                 fifo_rd_en,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic [NUM_CH-1:0]    pending,
    output logic [PTR_W-1:0]     ch_ptr
);

    localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PS_W-1:0]   ps_cnt;
    logic              tick;
    logic [CNT_W-1:0]  shadow_duty   [NUM_CH];
    logic [CNT_W-1:0]  shadow_period [NUM_CH];
    logic [CNT_W-1:0]  active_duty   [NUM_CH];
    logic [CNT_W-1:0]  active_period [NUM_CH];
    logic [CNT_W-1:0]  cnt           [NUM_CH];
    logic [NUM_CH-1:0] boundary;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] pending_next;

    assign tick = (ps_cnt == PS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    // A full shadow is never overwritten: the pop waits until that channel has applied it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty && !pending[ch_ptr]) state_next = READ;
            READ:    state_next = CAPT;
            CAPT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        boundary     = '0;
        apply        = '0;
        pending_next = pending;
        for (int i = 0; i < NUM_CH; i++) begin
            boundary[i] = (active_period[i] == '0) ||
                          (cnt[i] == active_period[i] - CNT_W'(1));
            apply[i]    = tick && boundary[i] && pending[i];
            if (apply[i]) pending_next[i] = 1'b0;
        end
        if (state == CAPT) pending_next[ch_ptr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            ch_ptr     <= '0;
            pending    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_duty[i]   <= '0;
                shadow_period[i] <= '0;
            end
        end else begin
            state      <= state_next;
            fifo_rd_en <= (state_next == READ);
            pending    <= pending_next;
            if (state == CAPT) begin
                shadow_duty[ch_ptr]   <= fifo_rd_data[2*CNT_W-1:CNT_W];
                shadow_period[ch_ptr] <= fifo_rd_data[CNT_W-1:0];
                ch_ptr <= (ch_ptr == PTR_LAST) ? '0 : ch_ptr + PTR_W'(1);
            end
        end
    end

    // Active settings change only at a boundary, so every period runs to completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                active_duty[i]   <= '0;
                active_period[i] <= '0;
                cnt[i]           <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (tick) begin
                    if (boundary[i]) begin
                        cnt[i] <= '0;
                        if (pending[i]) begin
                            active_duty[i]   <= shadow_duty[i];
                            active_period[i] <= shadow_period[i];
                        end
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
                pwm_out[i] <= (active_period[i] != '0) && (cnt[i] < active_duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_cmd_bank.sv
// tb/tb_pwm_cmd_bank.sv - scoreboard bench for pwm_cmd_bank: FIFO model, pop/capture log and
// a time-based waveform reference (phase = cycles since apply, mod period).
`timescale 1ns/1ps
module tb_pwm_cmd_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty;
    logic [15:0] fifo_rd_data = 16'h0;
    logic        fifo_rd_en;
    logic [3:0]  pwm_out;
    logic [3:0]  pending;
    logic [1:0]  ch_ptr;

    always #5 clk = ~clk;

    pwm_cmd_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .pwm_out      (pwm_out),
        .pending      (pending),
        .ch_ptr       (ch_ptr)
    );

    // FIFO model: stimulus writes mem/wr_ptr, this process owns rd_ptr and the pop log
    logic [15:0] mem    [256];
    logic [15:0] popped [4096];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pop_n  = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data        <= mem[rd_ptr[7:0]];
            popped[pop_n[11:0]] <= mem[rd_ptr[7:0]];
            pop_n               <= pop_n + 1;
            rd_ptr              <= rd_ptr + 1;
        end
    end

    int          vectors    = 0;
    int          miscompares = 0;
    int          n          = 0;
    int          tmo        = 0;
    int          tmo_seen   = 0;
    bit          end_req    = 1'b0;
    bit          end_done   = 1'b0;
    logic        rst_q      = 1'b0;
    int          act_t  [NUM_CH];
    logic [15:0] act_w  [NUM_CH];
    logic [15:0] sh_w   [NUM_CH];
    int          exp_ap [NUM_CH];
    logic [3:0]  prev_p  = '0;
    int          rr      = 0;
    int          cap_idx = 0;
    int          last_rd = -100;

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, n);
        end
    endtask

    function automatic bit exp_pwm(input int c, input int m);
        int p;
        int d;
        if (act_t[c] < 0) return 1'b0;
        p = int'(act_w[c][7:0]);
        d = int'(act_w[c][15:8]);
        if (p == 0) return 1'b0;
        return (((m - 1 - act_t[c]) % p) < d);
    endfunction

    // First clock edge after the capture at which the running period ends.
    function automatic int next_bnd(input int c, input int nc);
        int n0;
        int p;
        int k;
        n0 = nc + 1;
        if (act_t[c] < 0) return n0;
        p = int'(act_w[c][7:0]);
        if (p == 0) return n0;
        k = (n0 - act_t[c]) % p;
        return (k == 0) ? n0 : n0 + p - k;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            act_t[c]  = -1;
            act_w[c]  = 16'h0;
            sh_w[c]   = 16'h0;
            exp_ap[c] = 0;
        end
        prev_p  = '0;
        rr      = 0;
        cap_idx = pop_n;
        last_rd = -100;
    endtask

    initial model_reset();

    always @(negedge clk or negedge rst) begin
        if (rst_q && !rst) begin
            #1;
            chk(pwm_out == 4'h0, "async_rst_pwm_out", int'(pwm_out), 0);
            chk(fifo_rd_en == 1'b0, "async_rst_rd_en", int'(fifo_rd_en), 0);
            chk(pending == 4'h0, "async_rst_pending", int'(pending), 0);
            chk(ch_ptr == 2'd0, "async_rst_ch_ptr", int'(ch_ptr), 0);
            rst_q = 1'b0;
        end else begin
            logic [3:0] rises;
            logic [3:0] falls;
            n++;
            rst_q = rst;
            if (tmo != tmo_seen) begin
                chk(tmo == tmo_seen, "wait_timeout", tmo, tmo_seen);
                tmo_seen = tmo;
            end
            if (!rst) begin
                chk(pwm_out == 4'h0, "rst_pwm_out", int'(pwm_out), 0);
                chk(fifo_rd_en == 1'b0, "rst_rd_en", int'(fifo_rd_en), 0);
                chk(pending == 4'h0, "rst_pending", int'(pending), 0);
                chk(ch_ptr == 2'd0, "rst_ch_ptr", int'(ch_ptr), 0);
                model_reset();
            end else begin
                for (int c = 0; c < NUM_CH; c++)
                    chk(pwm_out[c] == exp_pwm(c, n), $sformatf("pwm_out[%0d]", c),
                        int'(pwm_out[c]), int'(exp_pwm(c, n)));
                if (fifo_rd_en) begin
                    chk(n - last_rd >= 3, "rd_en_spacing", n - last_rd, 3);
                    chk(!fifo_empty, "rd_en_while_empty", int'(fifo_empty), 0);
                    chk(pending[ch_ptr] == 1'b0, "rd_en_backpressure", int'(pending[ch_ptr]), 0);
                    last_rd = n;
                end
                rises = pending & ~prev_p;
                falls = ~pending & prev_p;
                chk($countones(rises) <= 1, "multi_capture", $countones(rises), 1);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (falls[c]) begin
                        chk(n == exp_ap[c], $sformatf("apply_cycle[%0d]", c), n, exp_ap[c]);
                        act_w[c] = sh_w[c];
                        act_t[c] = n;
                    end
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (rises[c]) begin
                        chk(c == rr, "capture_channel", c, rr);
                        chk(cap_idx < pop_n, "capture_without_pop", cap_idx, pop_n);
                        sh_w[c] = popped[cap_idx[11:0]];
                        cap_idx++;
                        rr = (rr + 1) % NUM_CH;
                        chk(int'(ch_ptr) == rr, "ch_ptr_advance", int'(ch_ptr), rr);
                        exp_ap[c] = next_bnd(c, n);
                    end else if (pending[c] && prev_p[c]) begin
                        chk(n <= exp_ap[c], $sformatf("apply_overdue[%0d]", c), n, exp_ap[c]);
                        if (n > exp_ap[c]) exp_ap[c] = n + 1000000;
                    end
                end
                prev_p = pending;
            end
            if (end_req && !end_done) begin
                chk(cap_idx == pop_n, "pops_all_captured", cap_idx, pop_n);
                chk(fifo_empty == 1'b1, "fifo_drained", int'(fifo_empty), 1);
                chk(pending == 4'h0, "pending_drained", int'(pending), 0);
                end_done = 1'b1;
            end
        end
    end

    task automatic wait_cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic push_word(input logic [15:0] w);
        int k;
        k = 0;
        while ((wr_ptr - rd_ptr) >= 8 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) tmo++;
        @(negedge clk);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [15:0] rand_word();
        int         r;
        logic [7:0] p;
        logic [7:0] d;
        r = int'($urandom_range(0, 9));
        case (r)
            0:       begin d = 8'h00; p = 8'($urandom_range(1, 30)); end
            1:       begin p = 8'h00; d = 8'($urandom_range(0, 255)); end
            2:       begin p = 8'($urandom_range(1, 30)); d = 8'(int'(p) + int'($urandom_range(0, 20))); end
            3:       begin p = 8'h01; d = 8'($urandom_range(0, 2)); end
            4:       begin p = 8'($urandom_range(150, 220)); d = 8'($urandom_range(0, 255)); end
            default: begin p = 8'($urandom_range(1, 40)); d = 8'($urandom_range(0, 40)); end
        endcase
        return {d, p};
    endfunction

    initial begin
        int k;
        rst = 1'b0;
        wait_cycles(3);
        #2 rst = 1'b1;
        wait_cycles(2);

        push_word(16'h0A1E);
        wait_cycles(80);
        push_word(16'h140A);
        push_word(16'h1E14);
        wait_cycles(50);
        push_word(16'h0005);
        push_word(16'h0500);
        wait_cycles(40);
        push_word(16'h0204);
        wait_cycles(40);
        for (int i = 0; i < 4; i++) push_word(16'h64C8);
        for (int i = 0; i < 5; i++) push_word(16'h0A1E);
        wait_cycles(30);

        push_word(16'h0A1E);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!fifo_rd_en && k < 2000);
        if (k >= 2000) begin
            tmo++;
        end else begin
            #1 rst = 1'b0;
            wait_cycles(3);
            #2 rst = 1'b1;
        end
        push_word(16'h0A1E);
        wait_cycles(60);

        for (int it = 0; it < 150; it++) begin
            int burst;
            wait_cycles(int'($urandom_range(0, 40)));
            burst = int'($urandom_range(1, 5));
            for (int b = 0; b < burst; b++) push_word(rand_word());
        end

        k = 0;
        while ((!fifo_empty || pending != 4'h0) && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 6000) tmo++;
        wait_cycles(40);
        end_req = 1'b1;
        wait_cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
